timebase_label_renderer: RTL and testbench
==========================================

Name: timebase_label_renderer

Overview:
Draws the oscilloscope time/div label ("1us" … "10s") as a pixel mask at a parametrised screen position and integer scale. The label is selected at run time and is re-latched only at frame start, so it never tears mid-frame. Optional blink. Output is a registered pixel bit that the VGA colour mux ORs with the other overlay layers.

Parameters:
X_ORIGIN, 245, left pixel column of the label box
Y_ORIGIN, 940, top pixel row of the label box
SCALE_LOG2, 0, glyph magnification is 2^SCALE_LOG2 (legal values 0..2)
NUM_CHARS, 5, number of character cells in the box
DEFAULT_SEL, 3, label index loaded at reset (3 = "1ms")
BLINK_FRAMES, 30, number of frames per blink half-period (legal values 1..255)

Ports:
CLK_VGA  in  1  pixel clock; the only clock
RST_N  in  1  synchronous active-low reset
VGA_horzCoord  in  12  current pixel column
VGA_vertCoord  in  12  current pixel row
TB_SEL  in  3  requested label index
BLINK_EN  in  1  1 = blink the label
LABEL_PIXEL  out  1  registered pixel mask, 2-cycle latency from coordinates
LABEL_UPDATED  out  1  one-cycle pulse when a new TB_SEL is latched

Behaviour:
- Reset (RST_N low at a CLK_VGA edge): LABEL_PIXEL=0, LABEL_UPDATED=0, sel_q=DEFAULT_SEL, frame counter=0, visible=1, pipeline registers=0, prev_vert=0.
- Frame start: frame_start = (prev_vert != 0) && (VGA_vertCoord == 0); prev_vert is registered every cycle. No strobe on the first frame after reset until a real wrap occurs.
- On frame_start: sel_q <= TB_SEL. LABEL_UPDATED pulses for 1 cycle only if TB_SEL != sel_q. A TB_SEL change mid-frame has no effect until the next frame_start.
- Label table (left-aligned, right-padded with spaces): 0 "1us", 1 "10us", 2 "100us", 3 "1ms", 4 "10ms", 5 "100ms", 6 "1s", 7 "10s".
- Char codes are 3 bits: 0 space, 1 '0', 2 '1', 3 '2', 4 '5', 5 'u', 6 'm', 7 's'.
- Each cell is 8x8 before scaling. Glyph is 5 wide x 7 tall in cell columns 0-4 and rows 0-6; cell columns 5-7 and row 7 are blank. Glyph bit 4 is the leftmost column.
- Glyph '1' rows 0-6: 00100, 01100, 00100, 00100, 00100, 00100, 01110. Full font lives in the package.
- Stage 1 (registered):
  - dx = horz - X_ORIGIN, dy = vert - Y_ORIGIN, both 12-bit unsigned.
  - in_box = (horz >= X_ORIGIN) && (dx < NUM_CHARS*8<<SCALE_LOG2) && (vert >= Y_ORIGIN) && (dy < 8<<SCALE_LOG2).
  - cx = dx>>SCALE_LOG2, cy = dy>>SCALE_LOG2.
  - Register char_idx = cx[..3], col = cx[2:0], row = cy[2:0], in_box.
- Stage 2 (registered):
  - Look up the char code from sel_q and char_idx, then the glyph bit.
  - LABEL_PIXEL <= in_box_q && glyph_bit && visible.
  - Out-of-box pixels and space cells give 0.
- Blink:
  - BLINK_EN=0: next cycle counter=0 and visible=1.
  - BLINK_EN=1: counter increments on each frame_start. When it reaches BLINK_FRAMES-1 it wraps to 0 and visible toggles.
- sel_q and visible change only at frame_start, which is outside the label box, so a frame never mixes two labels.
- Reset mid-frame or mid-blink: all state returns to reset values on that edge. LABEL_PIXEL is 0 on the next cycle.
- Coordinates near 4095 must not overflow the comparisons; the origin guard makes them safe.

Decomposition:
- Package timebase_label_pkg holds:
  - char code localparams
  - CELL_W=8, CELL_H=8, GLYPH_W=5, GLYPH_H=7
  - label table function (sel, idx -> char code)
  - font function (code, row -> 5-bit row bits)
- One sub-module, glyph_rom_5x7: combinational (code, row, col) -> bit, used in stage 2.

Test Plan:
- Reset, TB_SEL=3, scan (247,940) -> LABEL_PIXEL=1 two cycles later. (245,940) -> 0. (246,941) -> 1, from '1' row1 = 01100.
- TB_SEL=7 set at line 500, vert wraps 1079->0 -> LABEL_UPDATED pulses once at wrap. Pixels change only in the following frame.
- TB_SEL unchanged across a wrap -> LABEL_UPDATED stays 0.
- BLINK_FRAMES=2, BLINK_EN=1, 6 frames -> label visible frames 0-1, dark 2-3, visible 4-5. BLINK_EN=0 mid-dark -> visible next frame.
- SCALE_LOG2=1, TB_SEL=3 -> (249,940), (250,940), (249,941), (250,941) all 1. (248,940)=0 and (251,940)=0 (cell col 3 blank in '1' row0).
- Boundaries: (244,940), (285,940) with default scale, (247,948) -> 0. The 5th cell of "1ms" (x 277-284) is always 0.
- Synchronous RST_N low for 1 cycle mid-frame with sel_q=7 -> LABEL_PIXEL=0 next cycle. Label reverts to "1ms" immediately and blink phase resets.

Source files
------------

// File: rtl/timebase_label_pkg.sv
// rtl/timebase_label_pkg.sv - char codes, cell geometry, label table and 5x7 font for the time/div label
package timebase_label_pkg;

    localparam logic [2:0] CH_SP = 3'd0;
    localparam logic [2:0] CH_0  = 3'd1;
    localparam logic [2:0] CH_1  = 3'd2;
    localparam logic [2:0] CH_2  = 3'd3;
    localparam logic [2:0] CH_5  = 3'd4;
    localparam logic [2:0] CH_U  = 3'd5;
    localparam logic [2:0] CH_M  = 3'd6;
    localparam logic [2:0] CH_S  = 3'd7;

    localparam int CELL_W  = 8;
    localparam int CELL_H  = 8;
    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 7;

    // Label strings, left-aligned and padded with spaces; cell 0 sits in the top bits.
    function automatic logic [2:0] label_char(input logic [2:0] sel, input logic [8:0] idx);
        logic [14:0] s;
        case (sel)
            3'd0:    s = {CH_1, CH_U, CH_S, CH_SP, CH_SP};
            3'd1:    s = {CH_1, CH_0, CH_U, CH_S, CH_SP};
            3'd2:    s = {CH_1, CH_0, CH_0, CH_U, CH_S};
            3'd3:    s = {CH_1, CH_M, CH_S, CH_SP, CH_SP};
            3'd4:    s = {CH_1, CH_0, CH_M, CH_S, CH_SP};
            3'd5:    s = {CH_1, CH_0, CH_0, CH_M, CH_S};
            3'd6:    s = {CH_1, CH_S, CH_SP, CH_SP, CH_SP};
            default: s = {CH_1, CH_0, CH_S, CH_SP, CH_SP};
        endcase
        case (idx)
            9'd0:    label_char = s[14:12];
            9'd1:    label_char = s[11:9];
            9'd2:    label_char = s[8:6];
            9'd3:    label_char = s[5:3];
            9'd4:    label_char = s[2:0];
            default: label_char = CH_SP;
        endcase
    endfunction

    // Returns the 5 glyph columns of one row, bit 4 = leftmost; row 7 is the blank gap.
    function automatic logic [4:0] font_row(input logic [2:0] code, input logic [2:0] row);
        logic [34:0] g;
        case (code)
            CH_0:    g = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
            CH_1:    g = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
            CH_2:    g = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
            CH_5:    g = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
            CH_U:    g = {5'b00000, 5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b10011, 5'b01101};
            CH_M:    g = {5'b00000, 5'b00000, 5'b11010, 5'b10101, 5'b10101, 5'b10001, 5'b10001};
            CH_S:    g = {5'b00000, 5'b00000, 5'b01110, 5'b10000, 5'b01110, 5'b00001, 5'b11110};
            default: g = '0;
        endcase
        case (row)
            3'd0:    font_row = g[34:30];
            3'd1:    font_row = g[29:25];
            3'd2:    font_row = g[24:20];
            3'd3:    font_row = g[19:15];
            3'd4:    font_row = g[14:10];
            3'd5:    font_row = g[9:5];
            3'd6:    font_row = g[4:0];
            default: font_row = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/glyph_rom_5x7.sv
// rtl/glyph_rom_5x7.sv - combinational 5x7 glyph bit lookup within an 8x8 cell
// Ports: i_code char code, i_row cell row 0-7, i_col cell column 0-7, o_bit glyph pixel
module glyph_rom_5x7
    import timebase_label_pkg::*;
(
    input  logic [2:0] i_code,
    input  logic [2:0] i_row,
    input  logic [2:0] i_col,
    output logic       o_bit
);

    logic [4:0] w_row_bits;

    assign w_row_bits = font_row(i_code, i_row);

    // Columns 5-7 are the inter-character gap.
    always_comb begin
        o_bit = 1'b0;
        case (i_col)
            3'd0:    o_bit = w_row_bits[4];
            3'd1:    o_bit = w_row_bits[3];
            3'd2:    o_bit = w_row_bits[2];
            3'd3:    o_bit = w_row_bits[1];
            3'd4:    o_bit = w_row_bits[0];
            default: o_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/timebase_label_renderer.sv
// rtl/timebase_label_renderer.sv - renders the time/div label as a registered pixel mask
// Ports: CLK_VGA pixel clock, RST_N sync active-low reset, VGA_horzCoord/VGA_vertCoord scan position,
//        TB_SEL requested label, BLINK_EN blink enable, LABEL_PIXEL mask (2-cycle latency),
//        LABEL_UPDATED one-cycle pulse when a different label is latched at frame start
module timebase_label_renderer
    import timebase_label_pkg::*;
#(
    parameter int X_ORIGIN     = 245,
    parameter int Y_ORIGIN     = 940,
    parameter int SCALE_LOG2   = 0,
    parameter int NUM_CHARS    = 5,
    parameter int DEFAULT_SEL  = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        CLK_VGA,
    input  logic        RST_N,
    input  logic [11:0] VGA_horzCoord,
    input  logic [11:0] VGA_vertCoord,
    input  logic [2:0]  TB_SEL,
    input  logic        BLINK_EN,
    output logic        LABEL_PIXEL,
    output logic        LABEL_UPDATED
);

    localparam logic [11:0] L_X0    = 12'(X_ORIGIN);
    localparam logic [11:0] L_Y0    = 12'(Y_ORIGIN);
    localparam logic [11:0] L_BOX_W = 12'((NUM_CHARS * CELL_W) << SCALE_LOG2);
    localparam logic [11:0] L_BOX_H = 12'(CELL_H << SCALE_LOG2);
    localparam int          IDX_W   = 9 - SCALE_LOG2;
    localparam logic [7:0]  L_BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [2:0]  L_DEF_SEL    = 3'(DEFAULT_SEL);

    logic [11:0]      w_dx;
    logic [11:0]      w_dy;
    logic             w_in_box;
    logic             w_frame_start;
    logic [2:0]       w_char_code;
    logic             w_glyph_bit;

    logic [11:0]      r_prev_vert;
    logic [2:0]       r_sel;
    logic             r_updated;
    logic [7:0]       r_blink_cnt;
    logic             r_visible;
    logic             r_in_box;
    logic [IDX_W-1:0] r_char_idx;
    logic [2:0]       r_col;
    logic [2:0]       r_row;
    logic             r_pixel;

    // The >= origin terms stop a wrapped-around subtraction from looking in-box.
    assign w_dx     = VGA_horzCoord - L_X0;
    assign w_dy     = VGA_vertCoord - L_Y0;
    assign w_in_box = (VGA_horzCoord >= L_X0) && (w_dx < L_BOX_W) &&
                      (VGA_vertCoord >= L_Y0) && (w_dy < L_BOX_H);

    // A wrap to row 0 from a non-zero row; a freshly reset prev_vert of 0 suppresses a false strobe.
    assign w_frame_start = (r_prev_vert != 12'd0) && (VGA_vertCoord == 12'd0);

    assign w_char_code = label_char(r_sel, 9'(r_char_idx));

    glyph_rom_5x7 u_glyph_rom (
        .i_code (w_char_code),
        .i_row  (r_row),
        .i_col  (r_col),
        .o_bit  (w_glyph_bit)
    );

    // Label select and blink state move only at frame start, which lies outside the box.
    always_ff @(posedge CLK_VGA) begin
        if (!RST_N) begin
            r_prev_vert <= 12'd0;
            r_sel       <= L_DEF_SEL;
            r_updated   <= 1'b0;
            r_blink_cnt <= 8'd0;
            r_visible   <= 1'b1;
        end else begin
            r_prev_vert <= VGA_vertCoord;
            r_updated   <= 1'b0;
            if (w_frame_start) begin
                r_sel     <= TB_SEL;
                r_updated <= (TB_SEL != r_sel);
            end
            if (!BLINK_EN) begin
                r_blink_cnt <= 8'd0;
                r_visible   <= 1'b1;
            end else if (w_frame_start) begin
                if (r_blink_cnt == L_BLINK_LAST) begin
                    r_blink_cnt <= 8'd0;
                    r_visible   <= ~r_visible;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    // Stage 1: box test and cell addressing; stage 2: glyph lookup.
    always_ff @(posedge CLK_VGA) begin
        if (!RST_N) begin
            r_in_box   <= 1'b0;
            r_char_idx <= '0;
            r_col      <= 3'd0;
            r_row      <= 3'd0;
            r_pixel    <= 1'b0;
        end else begin
            r_in_box   <= w_in_box;
            r_char_idx <= w_dx[11:SCALE_LOG2+3];
            r_col      <= w_dx[SCALE_LOG2 +: 3];
            r_row      <= w_dy[SCALE_LOG2 +: 3];
            r_pixel    <= r_in_box && w_glyph_bit && r_visible;
        end
    end

    assign LABEL_PIXEL   = r_pixel;
    assign LABEL_UPDATED = r_updated;

endmodule

// File: tb/tb_timebase_label_renderer.sv
// tb/tb_timebase_label_renderer.sv - self-checking bench for timebase_label_renderer
module tb_timebase_label_renderer;

    logic        clk;
    logic        rst_n;
    logic [11:0] horz;
    logic [11:0] vert;
    logic [2:0]  tb_sel;
    logic        blink_en;
    logic        pix_def, upd_def;
    logic        pix_blk, upd_blk;
    logic        pix_s1, upd_s1;

    int n_checks = 0;
    int n_fail   = 0;

    timebase_label_renderer dut (
        .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(horz), .VGA_vertCoord(vert),
        .TB_SEL(tb_sel), .BLINK_EN(blink_en), .LABEL_PIXEL(pix_def), .LABEL_UPDATED(upd_def)
    );

    timebase_label_renderer #(.BLINK_FRAMES(2)) dut_blk (
        .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(horz), .VGA_vertCoord(vert),
        .TB_SEL(tb_sel), .BLINK_EN(blink_en), .LABEL_PIXEL(pix_blk), .LABEL_UPDATED(upd_blk)
    );

    timebase_label_renderer #(.SCALE_LOG2(1)) dut_s1 (
        .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(horz), .VGA_vertCoord(vert),
        .TB_SEL(tb_sel), .BLINK_EN(blink_en), .LABEL_PIXEL(pix_s1), .LABEL_UPDATED(upd_s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        scaled;
        logic        exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic add(input int h, input int v, input logic scaled, input logic exp);
        vec_t e;
        e.h = 12'(h); e.v = 12'(v); e.scaled = scaled; e.exp = exp;
        vecs.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic probe(input int h, input int v);
        horz = 12'(h);
        vert = 12'(v);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic wrap(input string nm, input logic exp_upd);
        horz = 12'd0;
        vert = 12'd1079;
        @(posedge clk); #1;
        vert = 12'd0;
        @(posedge clk); #1;
        chk({nm, "_upd_pulse"}, upd_def, exp_upd);
        vert = 12'd1;
        @(posedge clk); #1;
        chk({nm, "_upd_clear"}, upd_def, 1'b0);
    endtask

    initial begin
        logic [5:0] blink_pat;

        rst_n = 1'b0; horz = 12'd0; vert = 12'd0; tb_sel = 3'd3; blink_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pixel", pix_def, 1'b0);
        chk("reset_updated", upd_def, 1'b0);
        rst_n = 1'b1;

        // Default scale, label "1ms"
        add(247, 940, 0, 1); add(245, 940, 0, 0); add(246, 941, 0, 1);
        add(244, 940, 0, 0); add(285, 940, 0, 0); add(247, 948, 0, 0);
        add(279, 942, 0, 0); add(284, 947, 0, 0); add(247, 946, 0, 1);
        add(253, 942, 0, 1); add(256, 942, 0, 1); add(257, 942, 0, 0);
        add(262, 942, 0, 1); add(261, 942, 0, 0); add(250, 940, 0, 0);
        add(4095, 4095, 0, 0); add(4095, 940, 0, 0);
        // Scale x2
        add(249, 940, 1, 1); add(250, 940, 1, 1); add(249, 941, 1, 1);
        add(250, 941, 1, 1); add(248, 940, 1, 0); add(251, 940, 1, 0);
        add(248, 942, 1, 1); add(249, 955, 1, 0); add(245, 956, 1, 0);

        foreach (vecs[i]) begin
            probe(vecs[i].h, vecs[i].v);
            chk($sformatf("vec%0d_(%0d,%0d)", i, vecs[i].h, vecs[i].v),
                vecs[i].scaled ? pix_s1 : pix_def, vecs[i].exp);
        end

        wrap("same_sel", 1'b0);

        // TB_SEL change mid-frame is held off until the wrap
        probe(0, 500);
        tb_sel = 3'd7;
        probe(254, 940);
        chk("midframe_sel_hold", pix_def, 1'b0);
        wrap("sel7", 1'b1);
        probe(254, 940);
        chk("sel7_cell1_0", pix_def, 1'b1);
        probe(254, 942);
        chk("sel7_cell1_row2", pix_def, 1'b0);
        wrap("sel7_again", 1'b0);

        // Blink with BLINK_FRAMES=2: frames 0-1 lit, 2-3 dark, 4-5 lit
        blink_pat = 6'b110011;
        blink_en = 1'b1;
        probe(247, 940);
        chk("blink_f0", pix_blk, blink_pat[0]);
        for (int f = 1; f < 6; f++) begin
            wrap($sformatf("blink_w%0d", f), 1'b0);
            probe(247, 940);
            chk($sformatf("blink_f%0d", f), pix_blk, blink_pat[f]);
            if (f == 2) chk("slow_blink_f2", pix_def, 1'b1);
        end
        wrap("blink_w6", 1'b0);
        probe(247, 940);
        chk("blink_f6_dark", pix_blk, 1'b0);
        blink_en = 1'b0;
        probe(247, 940);
        chk("blink_off_now", pix_blk, 1'b1);
        wrap("blink_w7", 1'b0);
        probe(247, 940);
        chk("blink_off_next_frame", pix_blk, 1'b1);

        blink_en = 1'b1;
        wrap("blink_w8", 1'b0);
        probe(247, 940);
        chk("blink_f8", pix_blk, 1'b1);
        wrap("blink_w9", 1'b0);
        probe(247, 940);
        chk("blink_f9_dark", pix_blk, 1'b0);
        wrap("blink_w10", 1'b0);
        probe(254, 940);
        chk("pre_reset_sel7", pix_def, 1'b1);
        chk("pre_reset_dark", pix_blk, 1'b0);

        // Mid-frame reset: pixel clears on that edge, label back to "1ms", blink phase restarts
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_pixel", pix_def, 1'b0);
        chk("midreset_pixel_s1", pix_s1, 1'b0);
        rst_n = 1'b1;
        probe(254, 940);
        chk("post_reset_1ms_row0", pix_def, 1'b0);
        probe(254, 942);
        chk("post_reset_1ms_row2", pix_def, 1'b1);
        probe(247, 940);
        chk("post_reset_visible", pix_blk, 1'b1);
        wrap("post_reset_w1", 1'b1);
        probe(247, 940);
        chk("post_reset_f1", pix_blk, 1'b1);
        wrap("post_reset_w2", 1'b0);
        probe(247, 940);
        chk("post_reset_f2_dark", pix_blk, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
